// File: rtl/alu_pkg.sv
// Shared widths and operation encodings for the 8-bit registered ALU.
package alu_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned RES_W  = 16;
    localparam int unsigned OP_W   = 2;

    localparam logic [OP_W-1:0] OP_ADD = 2'b00;
    localparam logic [OP_W-1:0] OP_SUB = 2'b01;
    localparam logic [OP_W-1:0] OP_MUL = 2'b10;
    localparam logic [OP_W-1:0] OP_DIV = 2'b11;

endpackage : alu_pkg

// File: rtl/alu_div8.sv
// Combinational 8-bit unsigned restoring divider; a zero divisor yields zero outputs.
module alu_div8
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder,
    output logic              div_by_zero
);

    logic [DATA_W:0]   rem;
    logic [DATA_W-1:0] quo;

    assign div_by_zero = (divisor == '0);

    // One shift-compare-subtract step per dividend bit, MSB first.
    always_comb begin
        rem = '0;
        quo = '0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            rem = {rem[DATA_W-1:0], dividend[i]};
            if (rem >= {1'b0, divisor}) begin
                rem    = rem - {1'b0, divisor};
                quo[i] = 1'b1;
            end
        end
    end

    assign quotient  = div_by_zero ? '0 : quo;
    assign remainder = div_by_zero ? '0 : rem[DATA_W-1:0];

endmodule : alu_div8

// File: rtl/alu.sv
// Single-cycle registered 8-bit ALU: add, sub, mul, div with divide-by-zero flag.
module alu
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [OP_W-1:0]   op,
    output logic              valid_out,
    output logic [RES_W-1:0]  result,
    output logic              error
);

    logic [DATA_W-1:0] div_quo;
    logic [DATA_W-1:0] div_rem;
    logic              div_zero;

    logic [RES_W-1:0]  add_res;
    logic [RES_W-1:0]  sub_res;
    logic [RES_W-1:0]  mul_res;

    logic [RES_W-1:0]  result_d, result_q;
    logic              error_d,  error_q;
    logic              valid_d,  valid_q;

    alu_div8 u_div (
        .dividend    (a),
        .divisor     (b),
        .quotient    (div_quo),
        .remainder   (div_rem),
        .div_by_zero (div_zero)
    );

    assign add_res = RES_W'({1'b0, a} + {1'b0, b});
    assign sub_res = RES_W'(a) - RES_W'(b);
    assign mul_res = RES_W'(a) * RES_W'(b);

    // Operation mux; outputs hold when no valid operation is presented.
    always_comb begin
        result_d = result_q;
        error_d  = error_q;
        valid_d  = 1'b0;
        if (valid_in) begin
            valid_d = 1'b1;
            error_d = 1'b0;
            unique case (op)
                OP_ADD:  result_d = add_res;
                OP_SUB:  result_d = sub_res;
                OP_MUL:  result_d = mul_res;
                OP_DIV: begin
                    result_d = {div_rem, div_quo};
                    error_d  = div_zero;
                end
                default: result_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            error_q  <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            result_q <= result_d;
            error_q  <= error_d;
            valid_q  <= valid_d;
        end
    end

    assign result    = result_q;
    assign error     = error_q;
    assign valid_out = valid_q;

endmodule : alu

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed cases plus randomized traffic against an arithmetic model.
module tb_alu;

    logic        clk;
    logic        rst;
    logic        valid_in;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [1:0]  op;
    logic        valid_out;
    logic [15:0] result;
    logic        error;

    int n_cmp;
    int n_err;

    logic [15:0] exp_res;
    logic        exp_err;
    logic        exp_vld;

    alu dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .a         (a),
        .b         (b),
        .op        (op),
        .valid_out (valid_out),
        .result    (result),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference arithmetic from the operation definitions, using plain integers.
    task automatic model(input int x, input int y, input int o,
                         output logic [15:0] r, output logic e);
        int v;
        e = 1'b0;
        case (o)
            0: v = x + y;
            1: v = (x - y + 65536) % 65536;
            2: v = x * y;
            default: begin
                if (y == 0) begin
                    v = 0;
                    e = 1'b1;
                end else begin
                    v = (x % y) * 256 + (x / y);
                end
            end
        endcase
        r = v[15:0];
    endtask

    // Drive one cycle at negedge, advance the model, sample 1 time unit after posedge.
    task automatic step(input string tag, input logic r_i, input logic v_i,
                        input logic [7:0] a_i, input logic [7:0] b_i, input logic [1:0] op_i);
        logic [15:0] mr;
        logic        me;
        @(negedge clk);
        rst      = r_i;
        valid_in = v_i;
        a        = a_i;
        b        = b_i;
        op       = op_i;
        @(posedge clk);
        #1;
        if (r_i) begin
            exp_res = 16'h0;
            exp_err = 1'b0;
            exp_vld = 1'b0;
        end else if (v_i) begin
            model(int'(a_i), int'(b_i), int'(op_i), mr, me);
            exp_res = mr;
            exp_err = me;
            exp_vld = 1'b1;
        end else begin
            exp_vld = 1'b0;
        end
        check({tag, ".valid"},  32'(valid_out), 32'(exp_vld));
        check({tag, ".result"}, 32'(result),    32'(exp_res));
        check({tag, ".error"},  32'(error),     32'(exp_err));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        exp_res  = '0;
        exp_err  = 1'b0;
        exp_vld  = 1'b0;
        rst      = 1'b1;
        valid_in = 1'b0;
        a        = '0;
        b        = '0;
        op       = '0;

        // Reset overrides valid operands.
        step("rst0", 1'b1, 1'b1, 8'd200, 8'd0,  2'b11);
        step("rst1", 1'b1, 1'b1, 8'd99,  8'd77, 2'b10);

        step("add1",  1'b0, 1'b1, 8'd10,  8'd20, 2'b00);
        check("add1.lit", 32'(result), 32'd30);
        step("sub1",  1'b0, 1'b1, 8'd30,  8'd15, 2'b01);
        check("sub1.lit", 32'(result), 32'd15);
        step("subneg", 1'b0, 1'b1, 8'd5,  8'd10, 2'b01);
        check("subneg.lit", 32'(result), 32'hFFFB);
        step("addcy", 1'b0, 1'b1, 8'd255, 8'd1,  2'b00);
        check("addcy.lit", 32'(result), 32'h0100);
        step("mul1",  1'b0, 1'b1, 8'd5,   8'd3,  2'b10);
        check("mul1.lit", 32'(result), 32'd15);
        step("mulmax", 1'b0, 1'b1, 8'd255, 8'd255, 2'b10);
        check("mulmax.lit", 32'(result), 32'hFE01);
        step("div1",  1'b0, 1'b1, 8'd40,  8'd8,  2'b11);
        check("div1.lit", 32'(result), 32'h0005);
        step("div2",  1'b0, 1'b1, 8'd43,  8'd8,  2'b11);
        check("div2.lit", 32'(result), 32'h0305);
        step("divz",  1'b0, 1'b1, 8'd40,  8'd0,  2'b11);
        check("divz.err", 32'(error), 32'd1);
        step("nosticky", 1'b0, 1'b1, 8'd1, 8'd1, 2'b00);
        check("nosticky.lit", 32'(result), 32'd2);

        // Idle cycle after a divide-by-zero: result and error hold.
        step("divz2", 1'b0, 1'b1, 8'd7, 8'd0, 2'b11);
        step("hold",  1'b0, 1'b0, 8'd3, 8'd3, 2'b10);
        check("hold.err", 32'(error), 32'd1);

        // Back-to-back stream then idle.
        step("strm0", 1'b0, 1'b1, 8'd100, 8'd7,  2'b11);
        step("strm1", 1'b0, 1'b1, 8'd17,  8'd200, 2'b01);
        step("strm2", 1'b0, 1'b1, 8'd16,  8'd16, 2'b10);
        step("strm3", 1'b0, 1'b1, 8'd128, 8'd128, 2'b00);
        step("idle",  1'b0, 1'b0, 8'd1,   8'd2,  2'b00);
        check("idle.lit", 32'(result), 32'h0100);

        // Mid-stream reset drops the operation, next op is normal.
        step("mrst",  1'b1, 1'b1, 8'd9, 8'd9, 2'b10);
        step("post",  1'b0, 1'b1, 8'd9, 8'd4, 2'b11);

        for (int i = 0; i < 400; i++) begin
            logic       r_r;
            logic       v_r;
            logic [7:0] a_r;
            logic [7:0] b_r;
            logic [1:0] o_r;
            r_r = ($urandom_range(0, 31) == 0);
            v_r = ($urandom_range(0, 3) != 0);
            a_r = 8'($urandom);
            b_r = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            o_r = 2'($urandom);
            step("rand", r_r, v_r, a_r, b_r, o_r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_alu
